hermitian_desorter: RTL and testbench
=====================================

Name: hermitian_desorter

Overview:
Receive-side counterpart of the transmit sorter. It takes the serial complex FFT output stream of one OFDM symbol (FFT_LEN bins, framed by sop/eop) and extracts the NUM_DATA data subcarriers at bins 1..NUM_DATA. It checks the mirrored bins FFT_LEN-k against the conjugate of bin k, and reports a per-frame symmetry/framing status. It sits between the FFT core output and the demapper.

Parameters:
WIDTH, 8, bit width of each real/imag sample (two's complement)
FFT_LEN, 16, bins per frame; power of 2
NUM_DATA, 4, data subcarriers per frame; 2*NUM_DATA+1 <= FFT_LEN
TOL, 1, max allowed absolute mismatch per component in the symmetry check

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
in_valid  in  1  input sample qualifier
in_sop  in  1  first bin of frame (bin 0); valid only with in_valid
in_eop  in  1  last bin of frame; valid only with in_valid
in_re  in  WIDTH  bin real part
in_im  in  WIDTH  bin imag part
data_valid  out  1  data_re/data_im/data_idx valid
data_re  out  WIDTH  recovered data real part
data_im  out  WIDTH  recovered data imag part
data_idx  out  clog2(FFT_LEN)  subcarrier index, 1..NUM_DATA
frame_done  out  1  one-cycle pulse at end of frame
sym_err  out  1  valid with frame_done; 1 = at least one mirror bin out of tolerance
frame_err  out  1  valid with frame_done; 1 = framing violation (frame aborted)

Behaviour:
- Reset: synchronous, active-low. Sampled on rising clk edge. All outputs are 0, state is IDLE, bin counter is 0, buffer contents are don't-care. Reset mid-frame discards the frame; no frame_done is produced.
- States: IDLE, RECV.
  - IDLE: accepted sample (in_valid=1) without in_sop is ignored. in_valid & in_sop → bin 0 accepted, go to RECV, bin counter becomes 1.
  - RECV: each in_valid sample takes the current bin index, then the counter increments. in_valid=0 → hold; no advance, no outputs.
- Data bins 1..NUM_DATA: sample is stored in buffer[idx] and registered to the outputs. data_valid=1, data_idx=idx, latency 1 cycle. No backpressure.
- Null bins (0, NUM_DATA+1 .. FFT_LEN-NUM_DATA-1): discarded, not checked.
- Mirror bins j = FFT_LEN-NUM_DATA .. FFT_LEN-1, with k = FFT_LEN-j:
  - Mismatch if |in_re - buf_re[k]| > TOL or |in_im + buf_im[k]| > TOL.
  - Arithmetic is done in WIDTH+2 bits with no saturation, so -128 is handled exactly.
  - Any mismatch sets the sticky per-frame sym_acc.
- Normal end: in_eop on bin FFT_LEN-1. Next cycle: frame_done=1, sym_err=sym_acc, frame_err=0. State returns to IDLE and sym_acc clears.
- in_eop on any bin < FFT_LEN-1: next cycle frame_done=1, frame_err=1, sym_err=0. Go to IDLE.
- Bin FFT_LEN-1 accepted without in_eop: treated as eop (frame_done, sym_err=sym_acc), with frame_err=1. Go to IDLE.
- in_sop in RECV (mid-frame restart):
  - Next cycle: frame_done=1, frame_err=1, sym_err=0 for the aborted frame.
  - The sop sample is taken as bin 0 of the new frame; stay in RECV with counter 1 and sym_acc cleared.
  - in_sop wins over a simultaneous in_eop.
- sop and eop together in IDLE: frame_err pulse next cycle; stay IDLE.
- Data outputs are registered. data_re/data_im/data_idx hold their last value when data_valid=0. frame_done, sym_err and frame_err are 0 outside the pulse.

Decomposition:
- Shared package ofdm_pkg holds:
  - WIDTH, FFT_LEN and NUM_DATA defaults
  - IDX_W = clog2(FFT_LEN)
  - state encoding (IDLE=0, RECV=1)
  - the bin-class helper function (is_data, is_mirror)
- One sub-module, hermitian_check (combinational, parameterized WIDTH/TOL): inputs are the mirror sample and the stored sample; output is mismatch. It is reusable by the transmit-side self-test.

Test Plan:
- Clean frame (FFT_LEN=16, NUM_DATA=4):
  - Bins 1..4 = (10,-3), (20,5), (-30,7), (40,-8).
  - Bins 12..15 = (40,8), (-30,-7), (20,-5), (10,3); others 0.
  - Expect data_valid on 4 cycles, idx 1..4 with those values, each 1 cycle after input. Then frame_done with sym_err=0 and frame_err=0.
- Tolerance: repeat with bin15=(11,3) → sym_err=0. With bin15=(12,3) → sym_err=1. With bin14=(20,-3) → sym_err=1.
- Edge value: bin2=(-128,-128), bin14=(-128,127) → sym_err=0 (im sum -1 ≤ TOL), no overflow.
- Gaps: clean frame with in_valid low for 2 cycles after bins 3 and 13 → identical outputs, only delayed; frame_done once.
- Framing:
  - eop at bin 9 → frame_done, frame_err=1, sym_err=0.
  - sop at bin 6 → abort pulse, then the following clean frame reports frame_err=0.
  - 16 bins with no eop → frame_err=1.
- Reset: reset_n=0 for 1 cycle at bin 7 → all outputs 0 next cycle, no frame_done. Samples without sop are ignored until the next sop.

Source files
------------

// File: rtl/ofdm_pkg.sv
// Shared OFDM receive/transmit definitions: default sizes, FSM encoding and
// bin-classification helpers used by the sorter/desorter pair.
package ofdm_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_FFT_LEN  = 16;
  localparam int unsigned DEF_NUM_DATA = 4;
  localparam int unsigned IDX_W        = $clog2(DEF_FFT_LEN);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Data subcarriers occupy bins 1..num_data.
  function automatic logic is_data(input int unsigned bin, input int unsigned num_data);
    return (bin >= 1) && (bin <= num_data);
  endfunction

  // Mirror bins carry the conjugates of the data bins at the top of the spectrum.
  function automatic logic is_mirror(input int unsigned bin, input int unsigned fft_len,
                                     input int unsigned num_data);
    return (bin >= fft_len - num_data) && (bin < fft_len);
  endfunction

endpackage

// File: rtl/hermitian_check.sv
// Combinational conjugate-symmetry check of one mirror bin against its stored
// data bin; arithmetic is widened by two bits so no input value can overflow.
module hermitian_check #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TOL   = 1
) (
  input  logic [WIDTH-1:0] mir_re,
  input  logic [WIDTH-1:0] mir_im,
  input  logic [WIDTH-1:0] ref_re,
  input  logic [WIDTH-1:0] ref_im,
  output logic             mismatch
);

  localparam int unsigned EW = WIDTH + 2;

  logic signed [EW-1:0] d_re;
  logic signed [EW-1:0] s_im;
  logic        [EW-1:0] a_re;
  logic        [EW-1:0] a_im;

  // Conjugate: real parts must agree, imaginary parts must cancel.
  always_comb begin
    d_re = EW'($signed(mir_re)) - EW'($signed(ref_re));
    s_im = EW'($signed(mir_im)) + EW'($signed(ref_im));
    a_re = d_re[EW-1] ? $unsigned(-d_re) : $unsigned(d_re);
    a_im = s_im[EW-1] ? $unsigned(-s_im) : $unsigned(s_im);
    mismatch = (a_re > EW'(TOL)) || (a_im > EW'(TOL));
  end

endmodule

// File: rtl/hermitian_desorter.sv
// Receive-side desorter: pulls the data subcarriers out of a serial FFT frame,
// checks the mirrored bins for Hermitian symmetry and reports framing status.
module hermitian_desorter
  import ofdm_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned FFT_LEN  = DEF_FFT_LEN,
  parameter int unsigned NUM_DATA = DEF_NUM_DATA,
  parameter int unsigned TOL      = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic                       in_sop,
  input  logic                       in_eop,
  input  logic [WIDTH-1:0]           in_re,
  input  logic [WIDTH-1:0]           in_im,
  output logic                       data_valid,
  output logic [WIDTH-1:0]           data_re,
  output logic [WIDTH-1:0]           data_im,
  output logic [$clog2(FFT_LEN)-1:0] data_idx,
  output logic                       frame_done,
  output logic                       sym_err,
  output logic                       frame_err
);

  localparam int unsigned IW = $clog2(FFT_LEN);
  localparam int unsigned BW = $clog2(NUM_DATA + 1);
  localparam logic [IW-1:0] LAST_BIN = IW'(FFT_LEN - 1);

  state_t          state, state_n;
  logic [IW-1:0]   cnt, cnt_n;
  logic            sym_acc, sym_acc_n;
  logic            wr_en, done_n, serr_n, ferr_n;
  logic            is_last, mismatch, acc_upd;
  logic [BW-1:0]   mir_k;
  logic [WIDTH-1:0] ref_re, ref_im;

  // Buffer is sized to a power of two so every mir_k value is a legal index.
  logic [WIDTH-1:0] buf_re [2**BW];
  logic [WIDTH-1:0] buf_im [2**BW];

  // FFT_LEN is a power of two, so FFT_LEN-bin reduces to -bin modulo 2**BW.
  assign mir_k  = '0 - cnt[BW-1:0];
  assign ref_re = buf_re[mir_k];
  assign ref_im = buf_im[mir_k];

  hermitian_check #(
    .WIDTH (WIDTH),
    .TOL   (TOL)
  ) u_check (
    .mir_re   (in_re),
    .mir_im   (in_im),
    .ref_re   (ref_re),
    .ref_im   (ref_im),
    .mismatch (mismatch)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sym_acc_n = sym_acc;
    wr_en     = 1'b0;
    done_n    = 1'b0;
    serr_n    = 1'b0;
    ferr_n    = 1'b0;
    is_last   = (cnt == LAST_BIN);
    acc_upd   = sym_acc | (is_mirror(32'(cnt), FFT_LEN, NUM_DATA) & mismatch);

    case (state)
      IDLE: begin
        if (in_valid && in_sop) begin
          if (in_eop) begin
            done_n = 1'b1;
            ferr_n = 1'b1;
          end else begin
            state_n   = RECV;
            cnt_n     = IW'(1);
            sym_acc_n = 1'b0;
          end
        end
      end
      RECV: begin
        if (in_valid) begin
          if (in_sop) begin
            // Abort the running frame and restart on this sample as bin 0.
            done_n    = 1'b1;
            ferr_n    = 1'b1;
            cnt_n     = IW'(1);
            sym_acc_n = 1'b0;
          end else begin
            wr_en = is_data(32'(cnt), NUM_DATA);
            if (in_eop || is_last) begin
              state_n   = IDLE;
              cnt_n     = '0;
              sym_acc_n = 1'b0;
              done_n    = 1'b1;
              ferr_n    = !(in_eop && is_last);
              serr_n    = is_last & acc_upd;
            end else begin
              cnt_n     = cnt + 1'b1;
              sym_acc_n = acc_upd;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sym_acc    <= 1'b0;
      data_valid <= 1'b0;
      data_re    <= '0;
      data_im    <= '0;
      data_idx   <= '0;
      frame_done <= 1'b0;
      sym_err    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sym_acc    <= sym_acc_n;
      data_valid <= wr_en;
      frame_done <= done_n;
      sym_err    <= serr_n;
      frame_err  <= ferr_n;
      if (wr_en) begin
        data_re  <= in_re;
        data_im  <= in_im;
        data_idx <= cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_re[cnt[BW-1:0]] <= in_re;
      buf_im[cnt[BW-1:0]] <= in_im;
    end
  end

endmodule

// File: tb/tb_hermitian_desorter.sv
// Self-checking bench for hermitian_desorter: directed frame table, hand-written
// framing/reset sequences and random frames against a behavioural model.
module tb_hermitian_desorter;

  localparam int W   = 8;
  localparam int FL  = 16;
  localparam int ND  = 4;
  localparam int TOL = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sop = 1'b0;
  logic       in_eop = 1'b0;
  logic [7:0] in_re = '0;
  logic [7:0] in_im = '0;
  logic       data_valid;
  logic [7:0] data_re;
  logic [7:0] data_im;
  logic [3:0] data_idx;
  logic       frame_done;
  logic       sym_err;
  logic       frame_err;

  hermitian_desorter #(
    .WIDTH    (W),
    .FFT_LEN  (FL),
    .NUM_DATA (ND),
    .TOL      (TOL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_re      (in_re),
    .in_im      (in_im),
    .data_valid (data_valid),
    .data_re    (data_re),
    .data_im    (data_im),
    .data_idx   (data_idx),
    .frame_done (frame_done),
    .sym_err    (sym_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: frame position as an integer, stored data bins as ints.
  bit m_in = 1'b0;
  int m_bin = 0;
  int m_re [FL];
  int m_im [FL];
  bit m_acc = 1'b0;
  bit e_dv, e_done, e_serr, e_ferr;
  int e_re = 0, e_im = 0, e_idx = 0;

  bit [1:0] done_q [$];   // {sym_err, frame_err} of every frame_done pulse seen
  int fr_re [FL];
  int fr_im [FL];

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit rn, input bit v, input bit s, input bit e,
                       input int re, input int im);
    int b, k;
    bit last;
    e_dv = 0; e_done = 0; e_serr = 0; e_ferr = 0;
    if (!rn) begin
      m_in = 0; m_bin = 0; m_acc = 0; e_re = 0; e_im = 0; e_idx = 0;
      return;
    end
    if (!v) return;
    if (s) begin
      if (m_in) begin
        e_done = 1; e_ferr = 1;
      end else if (e) begin
        e_done = 1; e_ferr = 1;
        return;
      end
      m_in = 1; m_bin = 1; m_acc = 0;
      return;
    end
    if (!m_in) return;
    b = m_bin;
    if (b >= 1 && b <= ND) begin
      m_re[b] = re; m_im[b] = im;
      e_dv = 1; e_re = re; e_im = im; e_idx = b;
    end
    if (b >= FL - ND) begin
      k = FL - b;
      if (iabs(re - m_re[k]) > TOL || iabs(im + m_im[k]) > TOL) m_acc = 1;
    end
    last = (b == FL - 1);
    if (e || last) begin
      e_done = 1;
      e_ferr = !(e && last);
      e_serr = last ? m_acc : 1'b0;
      m_in = 0; m_acc = 0; m_bin = 0;
    end else begin
      m_bin++;
    end
  endtask

  task automatic step(input bit rn, input bit v, input bit s, input bit e,
                      input int re, input int im);
    logic [7:0] r8, i8;
    r8 = 8'(re);
    i8 = 8'(im);
    @(negedge clk);
    reset_n = rn; in_valid = v; in_sop = s; in_eop = e; in_re = r8; in_im = i8;
    model(rn, v, s, e, int'($signed(r8)), int'($signed(i8)));
    @(posedge clk);
    #1;
    check("cycle_outputs",
          64'({data_valid, data_idx, data_re, data_im, frame_done, sym_err, frame_err}),
          64'({e_dv, 4'(e_idx), 8'(e_re), 8'(e_im), e_done, e_serr, e_ferr}));
    if (frame_done) done_q.push_back({sym_err, frame_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom), int'($urandom));
  endtask

  // gap_mode: 0 none, 1 two idle cycles after bins 3 and 13, 2 random gaps
  task automatic send_range(input int first, input int last, input bit sop_first,
                            input int eop_bin, input int gap_mode);
    for (int b = first; b <= last; b++) begin
      step(1'b1, 1'b1, sop_first && (b == first), b == eop_bin, fr_re[b], fr_im[b]);
      if (gap_mode == 1 && (b == 3 || b == 13)) idle(2);
      if (gap_mode == 2 && $urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
    end
  endtask

  task automatic load_clean();
    for (int i = 0; i < FL; i++) begin fr_re[i] = 0; fr_im[i] = 0; end
    fr_re[1] = 10;  fr_im[1] = -3;
    fr_re[2] = 20;  fr_im[2] = 5;
    fr_re[3] = -30; fr_im[3] = 7;
    fr_re[4] = 40;  fr_im[4] = -8;
    fr_re[12] = 40;  fr_im[12] = 8;
    fr_re[13] = -30; fr_im[13] = -7;
    fr_re[14] = 20;  fr_im[14] = -5;
    fr_re[15] = 10;  fr_im[15] = 3;
  endtask

  typedef struct {
    string name;
    int    mb0, mr0, mi0;
    int    mb1, mr1, mi1;
    int    last_bin;
    int    eop_bin;
    int    gaps;
    bit    exp_sym;
    bit    exp_ferr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int n0, mode, cut;
    bit [1:0] got;

    vecs[0] = '{"clean",        -1, 0, 0,    -1, 0, 0,      15, 15, 0, 1'b0, 1'b0};
    vecs[1] = '{"tol_re_ok",    15, 11, 3,   -1, 0, 0,      15, 15, 0, 1'b0, 1'b0};
    vecs[2] = '{"tol_re_bad",   15, 12, 3,   -1, 0, 0,      15, 15, 0, 1'b1, 1'b0};
    vecs[3] = '{"tol_im_bad",   14, 20, -3,  -1, 0, 0,      15, 15, 0, 1'b1, 1'b0};
    vecs[4] = '{"edge_m128",    2, -128, -128, 14, -128, 127, 15, 15, 0, 1'b0, 1'b0};
    vecs[5] = '{"gaps",         -1, 0, 0,    -1, 0, 0,      15, 15, 1, 1'b0, 1'b0};
    vecs[6] = '{"eop_bin9",     -1, 0, 0,    -1, 0, 0,      9,  9,  0, 1'b0, 1'b1};
    vecs[7] = '{"no_eop",       -1, 0, 0,    -1, 0, 0,      15, -1, 0, 1'b0, 1'b1};
    vecs[8] = '{"no_eop_symbad", 15, 12, 3,  -1, 0, 0,      15, -1, 0, 1'b1, 1'b1};

    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 55, 66);
    idle(2);

    foreach (vecs[i]) begin
      load_clean();
      if (vecs[i].mb0 >= 0) begin fr_re[vecs[i].mb0] = vecs[i].mr0; fr_im[vecs[i].mb0] = vecs[i].mi0; end
      if (vecs[i].mb1 >= 0) begin fr_re[vecs[i].mb1] = vecs[i].mr1; fr_im[vecs[i].mb1] = vecs[i].mi1; end
      n0 = done_q.size();
      send_range(0, vecs[i].last_bin, 1'b1, vecs[i].eop_bin, vecs[i].gaps);
      idle(2);
      got = (done_q.size() > n0) ? done_q[n0] : 2'b00;
      check(vecs[i].name, 64'({done_q.size() - n0, got}),
            64'({1, vecs[i].exp_sym, vecs[i].exp_ferr}));
    end

    // Mid-frame sop: abort pulse for the old frame, then a clean report.
    load_clean();
    send_range(0, 5, 1'b1, -1, 0);
    n0 = done_q.size();
    send_range(0, 15, 1'b1, 15, 0);
    idle(2);
    check("sop_abort_count", 64'(done_q.size() - n0), 64'(2));
    if (done_q.size() >= n0 + 2) begin
      check("sop_abort_pulse", 64'(done_q[n0]), 64'(2'b01));
      check("sop_next_clean", 64'(done_q[n0 + 1]), 64'(2'b00));
    end

    // Reset at bin 7, then the tail of the frame without sop is ignored.
    load_clean();
    n0 = done_q.size();
    send_range(0, 6, 1'b1, -1, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, fr_re[7], fr_im[7]);
    check("reset_outputs_zero",
          64'({data_valid, data_idx, data_re, data_im, frame_done, sym_err, frame_err}), 64'(0));
    send_range(8, 15, 1'b0, 15, 0);
    idle(2);
    check("reset_no_done", 64'(done_q.size() - n0), 64'(0));
    send_range(0, 15, 1'b1, 15, 0);
    idle(1);
    check("reset_recover", 64'({done_q.size() - n0, done_q[done_q.size() - 1]}), 64'({1, 2'b00}));

    // sop together with eop while idle.
    n0 = done_q.size();
    step(1'b1, 1'b1, 1'b1, 1'b1, 5, 5);
    idle(2);
    check("idle_sop_eop", 64'({done_q.size() - n0, done_q[done_q.size() - 1]}), 64'({1, 2'b01}));

    // Random frames: near-Hermitian spectra with random noise, gaps and framing faults.
    for (int f = 0; f < 200; f++) begin
      for (int b = 0; b < FL; b++) begin
        fr_re[b] = int'($urandom_range(0, 255)) - 128;
        fr_im[b] = int'($urandom_range(0, 255)) - 128;
      end
      for (int k = 1; k <= ND; k++) begin
        fr_re[FL - k] = fr_re[k] + (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) - 2 : 0);
        fr_im[FL - k] = -fr_im[k] + (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) - 2 : 0);
      end
      if ($urandom_range(0, 3) == 0)
        for (int j = 0; j < int'($urandom_range(1, 3)); j++)
          step(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), int'($urandom), int'($urandom));
      mode = int'($urandom_range(0, 9));
      cut  = int'($urandom_range(1, 14));
      case (mode)
        0:       send_range(0, cut, 1'b1, cut, 2);
        1:       send_range(0, 15, 1'b1, -1, 2);
        2:       send_range(0, cut, 1'b1, -1, 2);
        default: send_range(0, 15, 1'b1, 15, 2);
      endcase
      if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
